car_request_conditioner: RTL
============================

Name: car_request_conditioner

Overview:
Upstream stage of the traffic-light controller. It turns a raw, asynchronous, bouncy east-west vehicle-loop sensor into a clean, latched `carew` request for the controller. The request is held until the controller reports east-west green, so a vehicle that stops briefly is never lost. Wait-time and request-count statistics are also exported.

Parameters:
- SYNC_STAGES, 2: flip-flops in the sensor synchronizer chain (>=2).
- DEBOUNCE_CYCLES, 8: consecutive synchronized-high samples needed to qualify a vehicle (>=2).
- CNT_W, 16: width of the wait-time counter.
- HOLDOFF_CYCLES, 32: post-service blanking length; used only when CARREQ_HOLDOFF_EN is defined.

Ports:
- clk, input, 1: system clock, rising edge.
- rstn, input, 1: asynchronous active-low reset.
- sensor_raw, input, 1: raw vehicle-loop sensor; asynchronous to clk.
- ew_green, input, 1: high while the controller shows east-west green (controller lights[0]).
- carew, output, 1: latched vehicle request to the controller.
- req_pending, output, 1: high while a vehicle is being qualified or is waiting.
- wait_cycles, output, CNT_W: length of the current or last wait in cycles; saturating.
- req_count, output, 8: number of requests served; wraps at 256.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Ports are clk and rstn.
- While rstn=0: state=IDLE, sync chain=0, debounce count=0, carew=0, req_pending=0, wait_cycles=0, req_count=0.
- Reset asserted mid-operation drops carew to 0 immediately, without waiting for a clock edge.
- Synchronizer:
  - sensor_raw passes through SYNC_STAGES flops to give sensor_s.
  - Only sensor_s is used downstream.
- FSM is Moore. States: IDLE, QUALIFY, REQUEST, SERVING (plus HOLDOFF under the macro).
- IDLE:
  - If sensor_s=1 and ew_green=0, go to QUALIFY and set deb_cnt=1.
  - Otherwise stay in IDLE.
- QUALIFY:
  - sensor_s=0 or ew_green=1: go to IDLE and clear deb_cnt. A car arriving during green is served by that green.
  - Otherwise, if deb_cnt==DEBOUNCE_CYCLES-1: go to REQUEST, clear wait_cycles to 0.
  - Otherwise: increment deb_cnt.
- REQUEST:
  - carew=1.
  - sensor_s is ignored; the request is latched.
  - wait_cycles increments by 1 per cycle and saturates at 2^CNT_W-1.
  - ew_green=1: go to SERVING and increment req_count (mod 256).
- SERVING:
  - carew=0; sensor_s is ignored.
  - Stay while ew_green=1.
  - ew_green=0: go to IDLE (or to HOLDOFF under the macro).
- Outputs:
  - carew = (state==REQUEST).
  - req_pending = (state==QUALIFY or state==REQUEST).
  - Both are decoded from the state register only; there is no combinational path from inputs.
- Latency: sensor_raw stable high with ew_green=0 raises carew exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples it high.
- Service response: carew falls on the first edge at which ew_green=1 is sampled in REQUEST.
- wait_cycles holds its last value outside REQUEST. It equals the number of cycles carew was high (saturated).
- Simultaneous events:
  - ew_green and the qualification threshold in the same cycle: go to IDLE; no request is raised.
  - ew_green=1 in REQUEST takes priority over sensor activity.

Optional Feature:
- Macro: CARREQ_HOLDOFF_EN.
- Defined:
  - SERVING with ew_green=0 goes to HOLDOFF. HOLDOFF lasts HOLDOFF_CYCLES cycles, uses its own counter, and ignores sensor_s.
  - HOLDOFF then goes to IDLE.
  - carew=0 and req_pending=0 in HOLDOFF.
  - This prevents a car still on the loop at end-of-green from re-triggering immediately.
- Undefined:
  - SERVING goes directly to IDLE.
  - No HOLDOFF state or counter is synthesized; HOLDOFF_CYCLES is ignored.

Decomposition:
- Package carreq_pkg holds:
  - the state enum typedef (IDLE, QUALIFY, REQUEST, SERVING, HOLDOFF);
  - default constants for SYNC_STAGES, DEBOUNCE_CYCLES, HOLDOFF_CYCLES and the req_count width (8).
- One sub-module, sync_chain:
  - parameterized depth, async active-low reset to 0;
  - instantiated once for sensor_raw.
- FSM, counters and output decode stay in the top module.

Test Plan:
Use defaults (SYNC_STAGES=2, DEBOUNCE_CYCLES=8) unless stated.
1. Reset: rstn low 2 cycles, then high. Required: carew=0, req_pending=0, wait_cycles=0, req_count=0. Outputs stay 0 with sensor_raw=0 for 20 cycles.
2. Clean arrival: sensor_raw=1 for 20 cycles, ew_green=0. Required: carew rises exactly 10 edges after the first sampled-high edge. carew stays 1 after sensor_raw returns to 0.
3. Bounce: sensor_raw repeats 5 cycles high / 1 cycle low for 60 cycles. Required: carew never asserts; req_pending toggles.
4. Service: hold in REQUEST for 30 cycles, then ew_green=1 for 5 cycles, then 0. Required: carew falls on the ew_green edge; wait_cycles=30; req_count=1; state returns to IDLE; a second arrival gives req_count=2.
5. Holdoff: sensor_raw held high through end-of-green. With CARREQ_HOLDOFF_EN, carew re-asserts 32+8 edges after ew_green falls. Without it, carew re-asserts 1+8 edges after ew_green falls.
6. Edge cases:
   - rstn pulsed low mid-REQUEST: carew=0 before the next clk edge.
   - CNT_W=4 with a 40-cycle wait: wait_cycles saturates at 15.

Source files
------------

// File: rtl/carreq_pkg.sv
// carreq_pkg
//   Shared types and default constants for the car request conditioner.
//   - state_e : FSM state encoding. HOLDOFF is reachable only when the
//               design is built with CARREQ_HOLDOFF_EN defined.
//   - DEF_*   : default parameter values for the top module.
//   - REQ_CNT_W : width of the served-request counter (wraps at 256).
package carreq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUALIFY = 3'd1,
        REQUEST = 3'd2,
        SERVING = 3'd3,
        HOLDOFF = 3'd4
    } state_e;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 8;
    localparam int DEF_HOLDOFF_CYCLES  = 32;
    localparam int DEF_CNT_W           = 16;
    localparam int REQ_CNT_W           = 8;

endpackage

// File: rtl/sync_chain.sv
// sync_chain
//   Multi-flop synchronizer for a single asynchronous level signal.
//   Ports:
//     clk  - destination clock, rising edge
//     rstn - asynchronous active-low reset, clears every stage to 0
//     d    - asynchronous input
//     q    - synchronized output, STAGES clock edges behind d
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Bit 0 is the metastability-catching stage; data shifts toward the MSB.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/car_request_conditioner.sv
// car_request_conditioner
//   Turns a raw, bouncy, asynchronous east-west vehicle-loop sensor into a
//   clean latched request (carew) for the traffic-light controller. The
//   request is held until the controller shows east-west green.
//
//   Optional build macro: CARREQ_HOLDOFF_EN
//     When defined, the end of an east-west green is followed by a
//     HOLDOFF_CYCLES blanking period in which the sensor is ignored, so a
//     car still sitting on the loop does not immediately re-request.
//
//   Ports:
//     clk         - system clock, rising edge
//     rstn        - asynchronous active-low reset
//     sensor_raw  - raw loop sensor, asynchronous to clk
//     ew_green    - high while the controller shows east-west green
//     carew       - latched vehicle request (state == REQUEST)
//     req_pending - vehicle being qualified or waiting
//     wait_cycles - cycles spent in the current/last REQUEST, saturating
//     req_count   - number of requests served, wraps at 256
//     dbg_state   - current FSM state encoding (state_e), for observation
//
//   Handshake: carew is a level request. It stays high from qualification
//   until the first clock edge that samples ew_green=1; that edge counts the
//   request as served. There is no separate acknowledge.
module car_request_conditioner
    import carreq_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 sensor_raw,
    input  logic                 ew_green,
    output logic                 carew,
    output logic                 req_pending,
    output logic [CNT_W-1:0]     wait_cycles,
    output logic [REQ_CNT_W-1:0] req_count,
    output logic [2:0]           dbg_state
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || HOLDOFF_CYCLES < 2 || CNT_W < 1) begin : g_param_check
        $error("car_request_conditioner: illegal parameter value");
    end

    logic sensor_s;

    state_e               state_q, state_d;
    logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0]     wait_q, wait_d;
    logic [REQ_CNT_W-1:0] count_q, count_d;

`ifdef CARREQ_HOLDOFF_EN
    localparam int HOLD_W = $clog2(HOLDOFF_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
`endif

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sensor_sync (
        .clk (clk),
        .rstn(rstn),
        .d   (sensor_raw),
        .q   (sensor_s)
    );

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            deb_cnt_q  <= '0;
            wait_q     <= '0;
            count_q    <= '0;
`ifdef CARREQ_HOLDOFF_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            wait_q     <= wait_d;
            count_q    <= count_d;
`ifdef CARREQ_HOLDOFF_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter update
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        wait_d     = wait_q;
        count_d    = count_q;
`ifdef CARREQ_HOLDOFF_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // A car arriving during green is served by that green.
                if (sensor_s && !ew_green) begin
                    state_d   = QUALIFY;
                    deb_cnt_d = DEB_W'(1);
                end
            end
            QUALIFY: begin
                // Green has priority over reaching the threshold.
                if (!sensor_s || ew_green) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = REQUEST;
                    deb_cnt_d = '0;
                    wait_d    = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            REQUEST: begin
                // Counted on every edge spent in REQUEST, including the
                // exiting one, so wait_cycles equals the cycles carew was high.
                if (wait_q != {CNT_W{1'b1}}) begin
                    wait_d = wait_q + 1'b1;
                end
                if (ew_green) begin
                    state_d = SERVING;
                    count_d = count_q + 1'b1;
                end
            end
            SERVING: begin
                if (!ew_green) begin
`ifdef CARREQ_HOLDOFF_EN
                    state_d    = HOLDOFF;
                    hold_cnt_d = HOLD_W'(1);
`else
                    state_d    = IDLE;
`endif
                end
            end
`ifdef CARREQ_HOLDOFF_EN
            HOLDOFF: begin
                // Entry edge counts as the first blanking cycle, so the FSM
                // is back in IDLE HOLDOFF_CYCLES edges after green drops.
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode (state register only)
    // ------------------------------------------------------------------
    always_comb begin
        carew       = (state_q == REQUEST);
        req_pending = (state_q == QUALIFY) || (state_q == REQUEST);
        wait_cycles = wait_q;
        req_count   = count_q;
        dbg_state   = state_q;
    end

endmodule
